// File: rtl/run_detector.sv
// Serial run detector: flags RUN_LEN consecutive equal bits on a qualified stream,
// reports the current run, and counts completed 0-runs and 1-runs with saturation.
module run_detector #(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LEN_W   = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             w,
  input  logic             hold_mode,
  input  logic             clr_cnt,
  output logic             out1,
  output logic             sym,
  output logic [LEN_W-1:0] run_len,
  output logic [CNT_W-1:0] zeros_cnt,
  output logic [CNT_W-1:0] ones_cnt
);

  localparam logic [LEN_W-1:0] LenMax = LEN_W'(RUN_LEN);
  localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic             sym_d;
  logic [LEN_W-1:0] len_d;
  logic             hit;
  logic             out1_d;
  logic [CNT_W-1:0] zeros_d;
  logic [CNT_W-1:0] ones_d;

  // Run tracking; a hit is only the transition into the saturated length.
  always_comb begin
    sym_d = sym;
    len_d = run_len;
    hit   = 1'b0;
    if (in_valid) begin
      if (run_len == '0 || w != sym) begin
        sym_d = w;
        len_d = LenOne;
      end else if (run_len != LenMax) begin
        len_d = run_len + LenOne;
      end
      hit = (len_d == LenMax) && (run_len != LenMax);
    end
    out1_d = hold_mode ? (len_d == LenMax) : hit;
  end

  // Clear beats a coincident hit; counters never wrap.
  always_comb begin
    zeros_d = zeros_cnt;
    ones_d  = ones_cnt;
    if (clr_cnt) begin
      zeros_d = '0;
      ones_d  = '0;
    end else if (hit) begin
      if (sym_d) begin
        if (ones_cnt != CntMax) ones_d = ones_cnt + CNT_W'(1);
      end else begin
        if (zeros_cnt != CntMax) zeros_d = zeros_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out1      <= 1'b0;
      sym       <= 1'b0;
      run_len   <= '0;
      zeros_cnt <= '0;
      ones_cnt  <= '0;
    end else begin
      out1      <= out1_d;
      sym       <= sym_d;
      run_len   <= len_d;
      zeros_cnt <= zeros_d;
      ones_cnt  <= ones_d;
    end
  end

endmodule

// File: tb/tb_run_detector.sv
// Directed bench for run_detector with RUN_LEN = 4, CNT_W = 4.
module tb_run_detector;

  localparam int unsigned RunLen = 4;
  localparam int unsigned CntW   = 4;
  localparam int unsigned LenW   = $clog2(RunLen + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            w;
  logic            hold_mode;
  logic            clr_cnt;
  logic            out1;
  logic            sym;
  logic [LenW-1:0] run_len;
  logic [CntW-1:0] zeros_cnt;
  logic [CntW-1:0] ones_cnt;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  run_detector #(
    .RUN_LEN(RunLen),
    .CNT_W  (CntW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .w        (w),
    .hold_mode(hold_mode),
    .clr_cnt  (clr_cnt),
    .out1     (out1),
    .sym      (sym),
    .run_len  (run_len),
    .zeros_cnt(zeros_cnt),
    .ones_cnt (ones_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic b);
    in_valid = v;
    w        = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int len_exp[5];
    int out_exp[6];

    reset     = 1'b0;
    in_valid  = 1'b0;
    w         = 1'b0;
    hold_mode = 1'b1;
    clr_cnt   = 1'b0;
    step(1'b1, 1'b1);
    chk("rst_out1", 32'(out1), 0);
    chk("rst_sym", 32'(sym), 0);
    chk("rst_len", 32'(run_len), 0);
    chk("rst_zeros", 32'(zeros_cnt), 0);
    chk("rst_ones", 32'(ones_cnt), 0);
    reset = 1'b1;

    // 1: five zeros, level mode
    len_exp = '{1, 2, 3, 4, 4};
    out_exp = '{0, 0, 0, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      chk($sformatf("s1_len%0d", i), 32'(run_len), 32'(len_exp[i]));
      chk($sformatf("s1_out%0d", i), 32'(out1), 32'(out_exp[i]));
    end
    chk("s1_zeros", 32'(zeros_cnt), 1);
    chk("s1_sym", 32'(sym), 0);

    // 2: 1,1,1,0,1 never completes a run
    len_exp = '{1, 2, 3, 1, 1};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, (i == 3) ? 1'b0 : 1'b1);
      chk($sformatf("s2_len%0d", i), 32'(run_len), 32'(len_exp[i]));
      chk($sformatf("s2_out%0d", i), 32'(out1), 0);
    end
    chk("s2_ones", 32'(ones_cnt), 0);

    // 3: pulse mode; a 0 first so the six 1s start a fresh run
    hold_mode = 1'b0;
    step(1'b1, 1'b0);
    out_exp = '{0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1);
      chk($sformatf("s3_out%0d", i), 32'(out1), 32'(out_exp[i]));
    end
    chk("s3_ones", 32'(ones_cnt), 1);
    chk("s3_len", 32'(run_len), 4);

    // 4: clear on an idle cycle, then zeros interleaved with idle cycles
    hold_mode = 1'b1;
    clr_cnt   = 1'b1;
    step(1'b0, 1'b0);
    clr_cnt = 1'b0;
    chk("s4_clr_ones", 32'(ones_cnt), 0);
    chk("s4_clr_len", 32'(run_len), 4);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      chk($sformatf("s4_len%0d", i), 32'(run_len), 32'(i + 1));
      step(1'b0, i[0] ? 1'b0 : 1'b1);
      chk($sformatf("s4_idle_len%0d", i), 32'(run_len), 32'(i + 1));
    end
    chk("s4_out", 32'(out1), 1);
    chk("s4_zeros", 32'(zeros_cnt), 1);

    // 5: seventeen 1-runs saturate ones_cnt
    for (int r = 0; r < 17; r++) begin
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      if (r == 14) chk("s5_ones15", 32'(ones_cnt), 15);
    end
    chk("s5_ones_sat", 32'(ones_cnt), 15);
    chk("s5_zeros", 32'(zeros_cnt), 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    clr_cnt = 1'b1;
    step(1'b1, 1'b1);
    clr_cnt = 1'b0;
    chk("s5_clr_ones", 32'(ones_cnt), 0);
    chk("s5_clr_zeros", 32'(zeros_cnt), 0);
    chk("s5_clr_out", 32'(out1), 1);
    chk("s5_clr_len", 32'(run_len), 4);

    // 6: reset mid-run wins over a valid sample
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    chk("s6_len3", 32'(run_len), 3);
    reset = 1'b0;
    step(1'b1, 1'b1);
    reset = 1'b1;
    chk("s6_rst_out1", 32'(out1), 0);
    chk("s6_rst_sym", 32'(sym), 0);
    chk("s6_rst_len", 32'(run_len), 0);
    chk("s6_rst_zeros", 32'(zeros_cnt), 0);
    chk("s6_rst_ones", 32'(ones_cnt), 0);
    step(1'b1, 1'b0);
    chk("s6_len1", 32'(run_len), 1);
    chk("s6_out", 32'(out1), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/run_detector.md
# run_detector

Parametrised successor to the fixed four-in-a-row detector. It watches a serial bit stream `w` and flags when RUN_LEN consecutive equal bits (all 0s or all 1s) have been seen. It adds several things the fixed version lacks: a sample-valid qualifier, a selectable level or pulse output mode, the detected symbol, the current run length, and saturating per-symbol event counters. It sits directly after the serial input stage, in the same place the fixed detector occupied.

## Interface
Parameters:
- RUN_LEN, 4, required run length; legal range >= 2.
- CNT_W, 8, width of each event counter.
- LEN_W, $clog2(RUN_LEN+1), width of run_len.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low (0 = reset); sampled on the rising edge of clk.
- in_valid  input  1  `w` is a real sample this cycle.
- w  input  1  serial data bit.
- hold_mode  input  1  1 = level output, 0 = single-cycle pulse output.
- clr_cnt  input  1  synchronous clear of both event counters.
- out1  output  1  detection flag.
- sym  output  1  symbol of the current run; meaningful when run_len != 0.
- run_len  output  LEN_W  current run length, saturating at RUN_LEN.
- zeros_cnt  output  CNT_W  number of completed 0-runs, saturating.
- ones_cnt  output  CNT_W  number of completed 1-runs, saturating.

## Operation
- Internal state: `sym`, `run_len`, `out1`, and the two counters. All outputs come straight from registers.
- Empty state: run_len = 0. The design is in this state only after reset.
- Run tracking, applied only on cycles with in_valid = 1:
  - If run_len == 0 or w != sym: sym <= w, run_len <= 1.
  - If w == sym: run_len <= min(run_len+1, RUN_LEN).
- Hit event: a valid sample moves run_len from RUN_LEN-1 to RUN_LEN. A sample taken while run_len is already RUN_LEN is not a new hit.
- out1 register, updated every cycle:
  - hold_mode = 1: out1 <= (run_len after this cycle's update == RUN_LEN). It stays high for as long as the run continues, including idle cycles.
  - hold_mode = 0: out1 <= hit event this cycle. This gives exactly one cycle high per run, and it is 0 on idle cycles.
- hold_mode is sampled every cycle. Switching it mid-run changes out1 at the next edge. Switching from 0 to 1 during a saturated run therefore raises out1 without producing a new hit.
- Counters: on a hit, zeros_cnt (sym 0) or ones_cnt (sym 1) increments by 1. Each counter saturates at 2^CNT_W-1 and never wraps.
- clr_cnt = 1 zeroes both counters. A hit in the same cycle is dropped, because clear wins. clr_cnt has no effect on run tracking or out1.
- in_valid = 0: sym, run_len and the counters hold their values; `w` is ignored.

## Timing
- Reset (reset = 0 at a rising edge): out1 = 0, sym = 0, run_len = 0, zeros_cnt = 0, ones_cnt = 0. Reset has priority over every other input.
- Reset asserted mid-run discards the partial run. The next valid sample starts a new run with run_len = 1.
- Latency: one cycle. The valid sample at edge k produces out1, run_len, sym and the counters visible after edge k.
- For RUN_LEN valid equal samples at edges k..k+RUN_LEN-1, out1 is high after edge k+RUN_LEN-1. This matches the fixed detector: 4 samples put out1 high in the cycle following the 4th edge.
- There is no back-pressure. Every valid sample is consumed in its own cycle.

## Test plan
Every scenario uses RUN_LEN = 4 and CNT_W = 4.
1. Reset, hold_mode = 1, then valid w = 0,0,0,0,0. Required:
   - run_len steps 1,2,3,4,4.
   - out1 rises after the 4th edge and stays 1 after the 5th.
   - zeros_cnt = 1, sym = 0.
2. Valid w = 1,1,1,0,1. Required:
   - run_len steps 1,2,3,1,1.
   - out1 stays 0 throughout, ones_cnt = 0.
3. hold_mode = 0, valid w = 1 six times. Required:
   - out1 is high for exactly one cycle, after the 4th edge.
   - ones_cnt = 1, run_len = 4.
4. w = 0 on four valid cycles, with in_valid = 0 cycles in between (w toggling on the idle cycles). Required:
   - Detection still happens: out1 goes to 1 and zeros_cnt = 1.
   - run_len holds its value across the idle cycles.
5. 17 repetitions of the pattern 1,1,1,1,0. Required:
   - ones_cnt saturates at 15.
   - Then assert clr_cnt in the same cycle as a further hit: ones_cnt = 0 afterwards.
6. Valid w = 0,0,0, then reset = 0 for one cycle, then valid w = 0. Required:
   - After the reset cycle, all outputs are 0.
   - After the final sample, run_len = 1 and out1 = 0.
